hilo_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit for the MiniSys-1A execute stage.
- Owns the HI/LO registers.
- Executes mult, multu, div, divu, and mthi/mtlo writes.
- hi/lo outputs feed the 32-bit 8:1 result-select mux for mfhi/mflo writeback; busy stalls the pipeline.

---
 rtl/hilo_muldiv_pkg.sv | 9 +
 rtl/hilo_muldiv.sv | 128 ++++++++++++
 tb/tb_hilo_muldiv.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared op/state encodings for the HI/LO multiply-divide unit.
package hilo_muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int ITER_LAST = 31;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;
endpackage

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle mult/multu/div/divu unit owning HI/LO, with mthi/mtlo writes.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e               state_q, state_d;
    logic                 div_q, div_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, div_zero_q, div_zero_d;
    logic                 signed_op, div_op, ge;
    logic [WIDTH-1:0]     mag_a, mag_b, diff;
    logic [WIDTH:0]       sum, shifted;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        signed_op  = (op == OP_MULT) || (op == OP_DIV);
        div_op     = (op == OP_DIV) || (op == OP_DIVU);
        mag_a      = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b      = (signed_op && b[WIDTH-1]) ? -b : b;
        // Multiply: add multiplicand into the upper half, keep the carry, shift right.
        sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: upper half is the remainder, lower half shifts dividend out / quotient in.
        shifted    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge         = shifted >= {1'b0, opnd_q};
        diff       = shifted[WIDTH-1:0] - opnd_q;
        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d    = S_CALC;
                    div_d      = div_op;
                    sa_d       = signed_op & a[WIDTH-1];
                    sb_d       = signed_op & b[WIDTH-1];
                    opnd_d     = div_op ? mag_b : mag_a;
                    acc_d      = {{WIDTH{1'b0}}, div_op ? mag_a : mag_b};
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = div_q ? {ge ? diff : shifted[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                              : {sum, acc_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(ITER_LAST)) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? -acc_q : acc_q;
                end else begin
                    // A zero divisor yields an all-ones quotient and remainder |a|, which sign-fixes back to a.
                    lo_d       = (opnd_q == '0) ? '1
                               : (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d       = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    div_zero_d = opnd_q == '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = state_q != S_IDLE;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed bench with a spec-level HI/LO model checked every cycle plus literal results.
module tb_hilo_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          checks = 0, failures = 0, done_cnt = 0;

    hilo_muldiv dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: return sx * sy;
            2'b01: return {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
        endcase
    endfunction

    logic        m_busy, m_done, m_dz, m_dz_next;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_dz <= 0; m_dz_next <= 0;
            m_hi <= 0; m_lo <= 0; m_res <= 0; m_left <= 0;
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start) begin
                    m_busy    <= 1;
                    m_left    <= 33;
                    m_res     <= ref_op(op, a, b);
                    m_dz      <= 0;
                    m_dz_next <= op[1] && b == 0;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    {m_hi, m_lo} <= m_res;
                    m_dz <= m_dz_next;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("div_zero", div_zero, m_dz);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    logic [1:0]  bb_op [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    logic [31:0] bb_a  [4] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bb_b  [4] = '{32'h0001_0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [63:0] bb_exp[4] = '{64'h0000_0001_0000_0000, 64'h0000_000F_0FFF_FFFF,
                               64'h0000_0000_0000_0001, 64'h0000_0000_8000_0000};

    initial begin
        int n, d0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        rst_n = 1;

        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_latency", n, 33);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        launch(2'b11, 32'd100, 32'd7);
        wait_done(n);
        chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

        launch(2'b10, 32'd5, 32'd0);
        wait_done(n);
        chk("div0_latency", n, 33);
        chk("div0_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        chk("div0_flag", div_zero, 1);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("dz_cleared", div_zero, 0);
        wait_done(n);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        launch(2'b00, 32'd1000, 32'hFFFF_FFFE);
        repeat (5) @(posedge clk);
        #1;
        d0 = done_cnt;
        start = 1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; hi_we = 1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 0; hi_we = 0;
        wait_done(n);
        chk("busy_ignore_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_F830);
        repeat (5) @(posedge clk);
        #1;
        chk("one_done_pulse", done_cnt - d0, 1);

        @(posedge clk); #1;
        hi_we = 1; lo_we = 1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        hi_we = 0; lo_we = 0;
        chk("mtx_hilo", {hi, lo}, 64'h1234_5678_1234_5678);
        chk("mtx_no_done", done, 0);

        launch(2'b00, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #3;
        d0 = done_cnt;
        rst_n = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_hilo", {hi, lo}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);

        @(posedge clk); #1;
        start = 1; op = bb_op[0]; a = bb_a[0]; b = bb_b[0];
        @(posedge clk); #1;
        op = bb_op[1]; a = bb_a[1]; b = bb_b[1];
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            chk("b2b_latency", n, 33);
            chk("b2b_hilo", {hi, lo}, bb_exp[i]);
            if (i == 3) begin
                start = 0;
            end else begin
                @(posedge clk); #1;
                if (i + 2 < 4) begin
                    op = bb_op[i+2]; a = bb_a[i+2]; b = bb_b[i+2];
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end
endmodule
